// File: rtl/scratchpad_responder.sv
// -----------------------------------------------------------------------------
// scratchpad_responder
//
// On-chip memory responder for the systolic array memory port. It serves
// single-beat reads with a fixed pipeline latency (READ_LATENCY edges from
// request sample to data presented). It accepts single-cycle writes from the
// array port, and it takes preload writes from a host port whenever the array
// port is idle.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous, active-low reset
//   mem_read_en    read request this cycle
//   mem_write_en   write request this cycle
//   mem_req_addr   beat address for the read/write request
//   mem_req_data   write data
//   mem_resp_data  read data; holds the last response between strobes
//   mem_resp_valid one-cycle strobe aligned with new mem_resp_data
//   host_we        host preload write request
//   host_addr      host write address
//   host_wdata     host write data
//   host_ready     host write accepted this cycle (array port idle)
//   oob_err        sticky flag, set by any out-of-range access
// -----------------------------------------------------------------------------
module scratchpad_responder #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned BANKING_FACTOR = 1,
    parameter int unsigned ADDRESS_WIDTH  = 13,
    parameter int unsigned DEPTH          = 4096,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 mem_read_en,
    input  logic                                 mem_write_en,
    input  logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
    input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_req_data,
    output logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data,
    output logic                                 mem_resp_valid,
    input  logic                                 host_we,
    input  logic [ADDRESS_WIDTH-1:0]             host_addr,
    input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] host_wdata,
    output logic                                 host_ready,
    output logic                                 oob_err
);

    localparam int unsigned BEAT_WIDTH  = BANKING_FACTOR * DATA_WIDTH;
    localparam int unsigned INDEX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDRESS_WIDTH is representable.
    localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(DEPTH);

    // Beat storage; deliberately not reset so preloaded tiles survive rst.
    logic [BEAT_WIDTH-1:0] storage [DEPTH];

    logic                   req_legal;
    logic                   host_legal;
    logic [INDEX_WIDTH-1:0] req_index;
    logic [INDEX_WIDTH-1:0] host_index;
    logic                   host_fire;
    logic [BEAT_WIDTH-1:0]  read_word;

    logic                   wr_en;
    logic [INDEX_WIDTH-1:0] wr_index;
    logic [BEAT_WIDTH-1:0]  wr_data;
    logic                   oob_event;

    logic                   tail_valid;
    logic [BEAT_WIDTH-1:0]  tail_data;

    // -------------------------------------------------------------------------
    // Address decode and arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        req_legal  = ({1'b0, mem_req_addr} < DEPTH_LIMIT);
        host_legal = ({1'b0, host_addr} < DEPTH_LIMIT);
        req_index  = mem_req_addr[INDEX_WIDTH-1:0];
        host_index = host_addr[INDEX_WIDTH-1:0];

        // The host only gets the array when the port is completely idle, so
        // host and port writes can never land on the same edge.
        host_ready = ~mem_read_en & ~mem_write_en;
        host_fire  = host_we & host_ready;

        // Out-of-range reads still occupy a response slot, carrying zero.
        read_word = req_legal ? storage[req_index] : '0;

        wr_en    = 1'b0;
        wr_index = req_index;
        wr_data  = mem_req_data;
        if (mem_write_en) begin
            wr_en = req_legal;
        end else if (host_fire) begin
            wr_en    = host_legal;
            wr_index = host_index;
            wr_data  = host_wdata;
        end

        oob_event = ((mem_read_en | mem_write_en) & ~req_legal)
                  | (host_fire & ~host_legal);
    end

    // -------------------------------------------------------------------------
    // Storage write port. A same-edge read sees the pre-write contents
    // because read_word is sampled from the array before this update lands.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            storage[wr_index] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Read pipe: the array word is captured at the sample edge. It then moves
    // through READ_LATENCY-1 stages, the last of which is the output register.
    // -------------------------------------------------------------------------
    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign tail_valid = mem_read_en;
            assign tail_data  = read_word;
        end else begin : g_pipe
            localparam int unsigned PIPE_DEPTH = READ_LATENCY - 1;

            logic [PIPE_DEPTH-1:0]                 pipe_valid;
            logic [PIPE_DEPTH-1:0][BEAT_WIDTH-1:0] pipe_data;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pipe_valid <= '0;
                    pipe_data  <= '0;
                end else begin
                    pipe_valid <= PIPE_DEPTH'({pipe_valid, mem_read_en});
                    pipe_data  <= (PIPE_DEPTH * BEAT_WIDTH)'({pipe_data, read_word});
                end
            end

            assign tail_valid = pipe_valid[PIPE_DEPTH-1];
            assign tail_data  = pipe_data[PIPE_DEPTH-1];
        end
    endgenerate

    // Output register: data only moves on a response so it holds in between.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_resp_valid <= 1'b0;
            mem_resp_data  <= '0;
        end else begin
            mem_resp_valid <= tail_valid;
            if (tail_valid) begin
                mem_resp_data <= tail_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sticky out-of-range flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oob_err <= 1'b0;
        end else if (oob_event) begin
            oob_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scratchpad_responder.sv
// -----------------------------------------------------------------------------
// tb_scratchpad_responder
//
// Drives one stimulus stream into two responders (READ_LATENCY 1 and 3). A
// behavioural memory model with per-edge response schedules predicts every
// output each cycle. Directed literal checks pin latency and data values.
// -----------------------------------------------------------------------------
module tb_scratchpad_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [12:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        host_we = 1'b0;
    logic [12:0] haddr = '0;
    logic [15:0] hdata = '0;

    logic [15:0] d1, d3;
    logic        v1, v3, hr1, hr3, oob1, oob3;

    always #5 clk = ~clk;

    scratchpad_responder #(
        .DATA_WIDTH(16), .BANKING_FACTOR(1), .ADDRESS_WIDTH(13),
        .DEPTH(4096), .READ_LATENCY(1)
    ) u_l1 (
        .clk(clk), .rst(rst),
        .mem_read_en(re), .mem_write_en(we),
        .mem_req_addr(addr), .mem_req_data(wdata),
        .mem_resp_data(d1), .mem_resp_valid(v1),
        .host_we(host_we), .host_addr(haddr), .host_wdata(hdata),
        .host_ready(hr1), .oob_err(oob1)
    );

    scratchpad_responder #(
        .DATA_WIDTH(16), .BANKING_FACTOR(1), .ADDRESS_WIDTH(13),
        .DEPTH(4096), .READ_LATENCY(3)
    ) u_l3 (
        .clk(clk), .rst(rst),
        .mem_read_en(re), .mem_write_en(we),
        .mem_req_addr(addr), .mem_req_data(wdata),
        .mem_resp_data(d3), .mem_resp_valid(v3),
        .host_we(host_we), .host_addr(haddr), .host_wdata(hdata),
        .host_ready(hr3), .oob_err(oob3)
    );

    int n_pass   = 0;
    int n_checks = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%b required=%b t=%0t", name, act, exp, $time);
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: memory array plus response schedules keyed by the
    // edge after which each response becomes visible.
    // ------------------------------------------------------------------
    logic [15:0] mm [4096];
    logic [15:0] sched1 [int];
    logic [15:0] sched3 [int];
    int          ecnt = 0;
    logic        ev1 = 1'b0, ev3 = 1'b0, m_oob = 1'b0;
    logic [15:0] ed1 = '0, ed3 = '0;

    task model_reset();
        sched1.delete();
        sched3.delete();
        ev1 = 1'b0; ev3 = 1'b0;
        ed1 = '0;   ed3 = '0;
        m_oob = 1'b0;
    endtask

    always @(negedge rst) model_reset();

    always @(posedge clk) begin
        logic [15:0] rv;
        logic        legal;
        if (!rst) begin
            model_reset();
        end else begin
            ecnt++;
            legal = (addr < 13'd4096);
            rv    = legal ? mm[addr[11:0]] : 16'h0000;
            if (re) begin
                sched1[ecnt]     = rv;
                sched3[ecnt + 2] = rv;
                if (!legal) m_oob = 1'b1;
            end
            if (sched1.exists(ecnt)) begin
                ev1 = 1'b1; ed1 = sched1[ecnt]; sched1.delete(ecnt);
            end else ev1 = 1'b0;
            if (sched3.exists(ecnt)) begin
                ev3 = 1'b1; ed3 = sched3[ecnt]; sched3.delete(ecnt);
            end else ev3 = 1'b0;
            if (we) begin
                if (legal) mm[addr[11:0]] = wdata;
                else m_oob = 1'b1;
            end else if (host_we && !re) begin
                if (haddr < 13'd4096) mm[haddr[11:0]] = hdata;
                else m_oob = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    int nv3 = 0;
    always @(negedge clk) begin
        chk1 ("valid_l1", v1, ev1);
        chk16("data_l1",  d1, ed1);
        chk1 ("oob_l1",   oob1, m_oob);
        chk1 ("valid_l3", v3, ev3);
        chk16("data_l3",  d3, ed3);
        chk1 ("oob_l3",   oob3, m_oob);
        chk1 ("host_ready_l1", hr1, !(re || we));
        chk1 ("host_ready_l3", hr3, !(re || we));
        if (v3 === 1'b1) nv3++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [12:0] a, input logic [15:0] d);
        host_we = 1'b1; haddr = a; hdata = d;
        #1;
        chk1("preload_ready", hr1, 1'b1);
        step();
        host_we = 1'b0;
    endtask

    initial begin
        int base;
        int n;

        #1 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // Preload tiles through the host port
        for (int i = 0; i <= 16; i++) host_wr(13'(i), 16'(i + 1));
        for (int i = 0; i < 16; i++) host_wr(13'h100 + 13'(i), 16'hA100 + 16'(i));
        host_wr(13'h020, 16'h00AA);
        step();

        // Readback of the preloaded words
        for (int i = 0; i < 16; i++) begin
            re = 1'b1; addr = 13'(i); step();
        end
        re = 1'b0;
        repeat (4) step();

        // Single read of 0x005: latency and hold
        re = 1'b1; addr = 13'h005; step(); re = 1'b0;
        chk1 ("lat1_valid", v1, 1'b1);
        chk16("lat1_data",  d1, 16'h0006);
        chk16("model_lat1", ed1, 16'h0006);
        n = 0;
        while (v3 !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk16("lat3_edges", 16'(n), 16'd2);
        chk16("lat3_data",  d3, 16'h0006);
        step();
        chk1 ("lat3_hold_valid", v3, 1'b0);
        chk16("lat3_hold_data",  d3, 16'h0006);
        chk16("lat1_hold_data",  d1, 16'h0006);
        repeat (3) step();

        // Streaming: 16 back-to-back reads
        base = nv3;
        for (int i = 0; i < 16; i++) begin
            re = 1'b1; addr = 13'h100 + 13'(i); step();
        end
        re = 1'b0;
        repeat (5) step();
        chk16("stream_count", 16'(nv3 - base), 16'd16);

        // Read and write same cycle, then read the next edge
        re = 1'b1; we = 1'b1; addr = 13'h010; wdata = 16'hBEEF; step();
        we = 1'b0;
        chk16("rw_old", d1, 16'h0011);
        step();
        re = 1'b0;
        chk16("rw_new",    d1,  16'hBEEF);
        chk16("model_rw",  ed1, 16'hBEEF);
        repeat (4) step();

        // Host collision: host request held while the port reads 0x020
        host_we = 1'b1; haddr = 13'h020; hdata = 16'h1234;
        re = 1'b1; addr = 13'h020;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("coll_ready", hr1, 1'b0);
            step();
        end
        chk16("coll_no_commit", d1, 16'h00AA);
        re = 1'b0;
        #1;
        chk1("coll_ready_idle", hr1, 1'b1);
        step();
        host_we = 1'b0;
        re = 1'b1; addr = 13'h020; step(); re = 1'b0;
        chk16("host_readback", d1, 16'h1234);
        repeat (4) step();

        // Out-of-range read
        re = 1'b1; addr = 13'h1FFF; step(); re = 1'b0;
        chk1 ("oob_valid", v1, 1'b1);
        chk16("oob_data",  d1, 16'h0000);
        chk1 ("oob_flag",  oob1, 1'b1);
        repeat (4) step();

        // Reset with two reads in flight in the L=3 pipe
        re = 1'b1; addr = 13'h000; step();
        addr = 13'h001; step();
        re = 1'b0;
        rst = 1'b0;
        #1;
        chk1("rst_oob",    oob3, 1'b0);
        chk1("rst_valid1", v1,   1'b0);
        base = nv3;
        repeat (2) step();
        rst = 1'b1;
        repeat (6) step();
        chk16("rst_no_strobe", 16'(nv3 - base), 16'd0);
        re = 1'b1; addr = 13'h003; step(); re = 1'b0;
        chk16("rst_intact_l1", d1, 16'h0004);
        repeat (3) step();
        chk16("rst_intact_l3", d3, 16'h0004);

        // Out-of-range port write and host write both set the flag
        we = 1'b1; addr = 13'h1000; wdata = 16'h5555; step(); we = 1'b0;
        chk1("oob_write", oob1, 1'b1);
        rst = 1'b0; step(); rst = 1'b1; step();
        host_wr(13'h1FFF, 16'h7777);
        chk1("oob_host", oob1, 1'b1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scratchpad_responder.md
# scratchpad_responder

Synthesizable memory responder for the systolic array's memory port. It replaces the testbench-only memory model and sits on the other end of the `mem_req_*`/`mem_resp_data` interface driven by `systolic_wrapper`. It serves single-word reads with a fixed, parameterized pipeline latency and accepts single-cycle writes (result writeback). A host preload port fills W/X tiles between runs.

## Interface
- `DATA_WIDTH`, 16: word width (signed two's-complement data, stored opaque).
- `BANKING_FACTOR`, 1: words per beat; all data buses are `BANKING_FACTOR*DATA_WIDTH` wide, one address per beat.
- `ADDRESS_WIDTH`, 13: request address width (beat address).
- `DEPTH`, 4096: implemented beats; legal range is 0..DEPTH-1, with DEPTH ≤ 2^ADDRESS_WIDTH.
- `READ_LATENCY`, 1: edges from read sample to data presented; range 1..8.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_read_en`  in  1  read request this cycle.
- `mem_write_en`  in  1  write request this cycle.
- `mem_req_addr`  in  ADDRESS_WIDTH  beat address for read/write.
- `mem_req_data`  in  BANKING_FACTOR*DATA_WIDTH  write data.
- `mem_resp_data`  out  BANKING_FACTOR*DATA_WIDTH  read data; holds last value between responses.
- `mem_resp_valid`  out  1  one-cycle strobe, aligned with new `mem_resp_data`.
- `host_we`  in  1  host preload write.
- `host_addr`  in  ADDRESS_WIDTH  host write address.
- `host_wdata`  in  BANKING_FACTOR*DATA_WIDTH  host write data.
- `host_ready`  out  1  host write accepted this cycle.
- `oob_err`  out  1  sticky flag: out-of-range access seen.

## Operation
- Storage is a DEPTH-entry array of beats. Reset does not clear its contents.
- Read: when `mem_read_en` is high at edge k with a legal address, the array word is captured at edge k. It then travels a (READ_LATENCY-1)-stage shift pipe.
- Every cycle may issue a new read; the block is fully pipelined with no backpressure. Responses return in issue order.
- Write: when `mem_write_en` is high at edge k with a legal address, the array is updated at edge k.
- Read and write in the same cycle (same address bus): the read is read-first and returns the pre-write data. The write still commits.
- Read issued at edge k+1 after a write at edge k to the same address returns the new data.
- Host port: `host_ready` = ~`mem_read_en` & ~`mem_write_en`, combinational. A host write commits at the edge where `host_we` & `host_ready`.
- When `host_ready` is low, `host_we` is ignored; the host holds its request and retries.
- Out-of-range address (≥ DEPTH):
  - A read still produces a response slot with data 0.
  - A write is dropped.
  - Either case sets `oob_err` until reset.
  - A host write to an out-of-range address is dropped and also sets `oob_err`.
- Reset mid-operation: in-flight reads are discarded, with no response strobes after reset release. Array writes committed before reset persist.

## Timing
- Reset values: `mem_resp_data` = 0, `mem_resp_valid` = 0, `oob_err` = 0, pipe valid bits = 0. `host_ready` follows its inputs.
- Latency: read sampled at edge k gives `mem_resp_valid` = 1 and new `mem_resp_data` during the cycle after edge k+READ_LATENCY-1.
  - READ_LATENCY = 1 is a registered single-cycle read.
  - `systolic_wrapper`'s MEM_LATENCY budget must equal READ_LATENCY plus its own request/capture register stages.
- `mem_resp_valid` is high for exactly one cycle per accepted read. Back-to-back reads give contiguous strobes.
- `oob_err` rises the edge the offending request is sampled.
- Host and port writes never land in the same edge.

## Test plan
- Preload: host writes 0x0001..0x0010 to addresses 0x000..0x00F with the port idle → `host_ready` = 1 throughout. Reads of 0x000..0x00F return 0x0001..0x0010.
- Latency sweep, READ_LATENCY ∈ {1, 3}: a single read of 0x005 at edge k → `mem_resp_valid` strobe after edge k+L-1 carrying 0x0006. `mem_resp_data` then holds 0x0006.
- Streaming: 16 back-to-back reads 0x100..0x10F → 16 contiguous valid cycles, in-order data, no gaps.
- Read/write same cycle at 0x010 (old 0x0011, write 0xBEEF) → response 0x0011. A read at the next edge returns 0xBEEF.
- Host collision: `host_we` with addr 0x020 held high while `mem_read_en` is high for 3 cycles → `host_ready` = 0 and no commit. The commit happens on the first idle cycle, and a readback returns the host data.
- Out of range and reset: with DEPTH = 4096, a read at 0x1FFF returns 0 with valid and `oob_err` = 1. Asserting `rst` low with 2 reads in flight (L = 3) → no strobes after release, `oob_err` = 0, array data intact.
